// File: rtl/arr_mult_4bit_pkg.sv
// Shared width constants for the 4x4 unsigned array multiplier.
package arr_mult_4bit_pkg;
    localparam int OP_W   = 4;
    localparam int PROD_W = 8;
endpackage

// File: rtl/arr_mult_4bit_full_adder.sv
// One-bit full adder cell; used as a half adder by tying cin low.
module arr_mult_4bit_full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    always_comb begin
        s    = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end
endmodule

// File: rtl/arr_mult_4bit.sv
// Unsigned 4x4 array multiplier: AND partial products reduced by three ripple
// rows of adder cells, with the 8-bit product registered once (async clear).
module arr_mult_4bit
    import arr_mult_4bit_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic [PROD_W-1:0] prod
);
    logic [OP_W-1:0][OP_W-1:0] pp;
    logic [3:1][OP_W-1:0]      upper;
    logic [3:1][OP_W-1:0]      sum;
    logic [3:1][OP_W-1:0]      co;
    logic [PROD_W-1:0]         prod_d;
    logic [PROD_W-1:0]         prod_q;

    // pp[i][j] weights bit i+j
    always_comb begin
        for (int i = 0; i < OP_W; i++) begin
            for (int j = 0; j < OP_W; j++) begin
                pp[i][j] = a[j] & b[i];
            end
        end
    end

    // Each row adds the previous row's upper sums and carry-out (shifted down
    // one weight) to its own partial-product word.
    always_comb begin
        upper[1] = {1'b0, pp[0][3:1]};
        upper[2] = {co[1][3], sum[1][3:1]};
        upper[3] = {co[2][3], sum[2][3:1]};
    end

    for (genvar r = 1; r <= 3; r++) begin : g_row
        for (genvar c = 0; c < OP_W; c++) begin : g_cell
            logic cin;
            if (c == 0) begin : g_lsb
                assign cin = 1'b0;
            end else begin : g_chain
                assign cin = co[r][c-1];
            end
            arr_mult_4bit_full_adder u_fa (
                .a    (pp[r][c]),
                .b    (upper[r][c]),
                .cin  (cin),
                .s    (sum[r][c]),
                .cout (co[r][c])
            );
        end
    end

    always_comb begin
        prod_d = {co[3][3], sum[3], sum[2][0], sum[1][0], pp[0][0]};
    end

    // ---- output register stage ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q <= '0;
        end else begin
            prod_q <= prod_d;
        end
    end

    assign prod = prod_q;
endmodule

// File: tb/tb_arr_mult_4bit.sv
// Self-checking bench for arr_mult_4bit: directed table, reset, latency and exhaustive sweep.
module tb_arr_mult_4bit;
    logic       clk;
    logic       rst_n;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] prod;

    int n_pass;
    int n_total;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [12];

    arr_mult_4bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .prod  (prod)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: prod=%h expected=%h", name, act, exp);
        end
    endtask

    initial begin
        logic [7:0] e;
        n_pass  = 0;
        n_total = 0;

        vecs[0]  = '{4'd13, 4'd9,  8'h75};
        vecs[1]  = '{4'd10, 4'd11, 8'h6E};
        vecs[2]  = '{4'd8,  4'd8,  8'h40};
        vecs[3]  = '{4'd15, 4'd1,  8'h0F};
        vecs[4]  = '{4'd5,  4'd4,  8'h14};
        vecs[5]  = '{4'd1,  4'd6,  8'h06};
        vecs[6]  = '{4'd15, 4'd15, 8'hE1};
        vecs[7]  = '{4'd0,  4'd15, 8'h00};
        vecs[8]  = '{4'd15, 4'd0,  8'h00};
        vecs[9]  = '{4'd7,  4'd1,  8'h07};
        vecs[10] = '{4'd12, 4'd12, 8'h90};
        vecs[11] = '{4'd3,  4'd14, 8'h2A};

        // Reset held with maximal operands
        rst_n = 1'b0;
        a     = 4'hF;
        b     = 4'hF;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("reset_hold", prod, 8'h00);
        end
        rst_n = 1'b1;

        // Directed vectors, back-to-back, one per cycle
        for (int i = 0; i < 12; i++) begin
            a = vecs[i].a;
            b = vecs[i].b;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_%0dx%0d", i, vecs[i].a, vecs[i].b), prod, vecs[i].exp);
        end

        // Mid-run asynchronous reset
        a = 4'd13;
        b = 4'd9;
        @(posedge clk);
        #1;
        check("pre_reset", prod, 8'h75);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_clear", prod, 8'h00);
        a = 4'd5;
        b = 4'd4;
        @(posedge clk);
        #1;
        check("clear_held", prod, 8'h00);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_release", prod, 8'h14);

        // Latency: inputs changed mid-cycle must not show until the next edge
        a = 4'd3;
        b = 4'd3;
        @(posedge clk);
        #1;
        check("lat_first", prod, 8'h09);
        a = 4'd7;
        b = 4'd7;
        #2;
        check("lat_hold", prod, 8'h09);
        @(posedge clk);
        #1;
        check("lat_next", prod, 8'h31);

        // Exhaustive sweep against the reference product
        for (int i = 0; i < 256; i++) begin
            a = i[7:4];
            b = i[3:0];
            e = 8'(a) * 8'(b);
            @(posedge clk);
            #1;
            check($sformatf("exh_%0dx%0d", a, b), prod, e);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
